regrd_arbiter: RTL

REGRD_ARBITER -- requirements
Module: regrd_arbiter

---
 rtl/regrd_pkg.sv | 21 ++
 rtl/regrd_arbiter_rr_pick.sv | 33 +++
 rtl/regrd_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/regrd_pkg.sv
// rtl/regrd_pkg.sv - shared defaults, FSM state type and helpers for the register-file read arbiter
// Contents:
//   NREQ_DEF, AW_DEF, DW_DEF : default requester count, address width, data width
//   arb_state_t              : control FSM states (ARB, LOCKED)
//   wrap_inc                 : modulo-n increment used for the round-robin pointer
package regrd_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1) % n;
    endfunction

endpackage

// File: rtl/regrd_arbiter_rr_pick.sv
// rtl/regrd_arbiter_rr_pick.sv - pointer-rotated priority pick
// Ports:
//   elig : eligible requester vector
//   ptr  : index where the priority search starts
//   win  : one-hot winner (all zero when none eligible)
//   vld  : a winner exists
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            vld
);

    logic [PW-1:0] j;

    // Walk from ptr upward with wrap; the first eligible bit wins.
    always_comb begin
        win = '0;
        vld = 1'b0;
        j   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (!vld && elig[j]) begin
                win[j] = 1'b1;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regrd_arbiter.sv
// rtl/regrd_arbiter.sv - round-robin arbiter for a shared register-file read port
// Optional feature: define REGRD_ARB_LOCK_EN to enable grant locking (LOCKED state).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req        : per-requester level read request
//   addr       : per-requester read address, slice i = requester i
//   lock       : per-requester grant-hold request (lock builds only)
//   s          : registered read-mux select
//   mux_z      : read-mux output for the current s
//   gnt        : one-hot issue-stage grant
//   ack        : one-hot one-cycle data-valid strobe
//   rd_data    : registered read data, valid with ack
//   busy       : a read is in the issue or return stage
module regrd_arbiter
    import regrd_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ-1:0]   lock,
    output logic [AW-1:0]     s,
    input  logic [DW-1:0]     mux_z,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rd_data,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win;
    logic            win_vld;
    logic [AW-1:0]   win_addr;

`ifdef REGRD_ARB_LOCK_EN
    arb_state_t      state;
    logic [PW-1:0]   lock_id;
`else
    logic            unused_lock;
    assign unused_lock = ^lock;
`endif

    // A requester is pending while its read sits in the issue (gnt) or
    // return (ack) stage, so gnt|ack is exactly the pending mask.
    always_comb begin
        elig = req & ~(gnt | ack);
`ifdef REGRD_ARB_LOCK_EN
        // While locked only the owner may win; the cycle its lock drops is
        // spent returning to ARB with no grant.
        if (state == LOCKED) begin
            elig = lock[lock_id] ? (elig & (NREQ'(1) << lock_id)) : '0;
        end
`endif
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .elig (elig),
        .ptr  (ptr),
        .win  (win),
        .vld  (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
            end
        end
        win_addr = addr[int'(win_idx)*AW +: AW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s       <= '0;
            gnt     <= '0;
            ack     <= '0;
            rd_data <= '0;
            busy    <= 1'b0;
            ptr     <= '0;
`ifdef REGRD_ARB_LOCK_EN
            state   <= ARB;
            lock_id <= '0;
`endif
        end else begin
            gnt  <= win;
            ack  <= gnt;
            busy <= win_vld | (|gnt);
            if (|gnt) begin
                rd_data <= mux_z;
            end
            if (win_vld) begin
                s   <= win_addr;
                ptr <= PW'(wrap_inc(int'(win_idx), NREQ));
            end
`ifdef REGRD_ARB_LOCK_EN
            case (state)
                ARB: begin
                    if (win_vld && lock[win_idx]) begin
                        state   <= LOCKED;
                        lock_id <= win_idx;
                    end
                end
                LOCKED: begin
                    if (!lock[lock_id]) begin
                        state <= ARB;
                        ptr   <= PW'(wrap_inc(int'(lock_id), NREQ));
                    end
                end
                default: state <= ARB;
            endcase
`endif
        end
    end

endmodule
